// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract: WIDTH bits split into STAGES segments,
// one segment resolved per stage, with valid/ready stall handshake and status flags.
module pipelined_cla_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;

  logic             w_advance;
  logic [WIDTH-1:0] r_inA;
  logic [WIDTH-1:0] r_inB;
  logic             r_inC;
  logic             r_inV;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_outValid;

  // Global enable: the whole pipe moves whenever the output slot is free or being drained.
  assign w_advance = out_ready || !r_outValid;
  assign in_ready  = w_advance;

  assign out_valid = r_outValid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign zero      = r_zero;

  // One segment: group generate/propagate chain the block carries, bits ripple within a block.
  function automatic logic [SEG:0] claSeg(input logic [SEG-1:0] a,
                                          input logic [SEG-1:0] b,
                                          input logic           c);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   carry;
    logic           gg;
    logic           gp;
    g        = a & b;
    p        = a ^ b;
    carry    = '0;
    carry[0] = c;
    for (int grp = 0; grp < SEG / GROUP; grp++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = g[grp*GROUP+i] | (p[grp*GROUP+i] & gg);
        gp = gp & p[grp*GROUP+i];
      end
      for (int i = 0; i < GROUP - 1; i++) begin
        carry[grp*GROUP+i+1] = g[grp*GROUP+i] | (p[grp*GROUP+i] & carry[grp*GROUP+i]);
      end
      carry[(grp+1)*GROUP] = gg | (gp & carry[grp*GROUP]);
    end
    return {carry[SEG], p ^ carry[SEG-1:0]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inV <= 1'b0;
    end else if (w_advance) begin
      r_inV <= in_valid;
    end
  end

  // Subtraction is folded in here so every later stage is a plain adder.
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_inA <= in1;
      r_inB <= op ? ~in2 : in2;
      r_inC <= cin;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:k*SEG]     w_a;
    logic [WIDTH-1:k*SEG]     w_b;
    logic                     w_c;
    logic                     w_v;
    logic [SEG:0]             w_seg;
    logic [(k+1)*SEG-1:0]     w_low;

    if (k == 0) begin : g_src
      assign w_a   = r_inA;
      assign w_b   = r_inB;
      assign w_c   = r_inC;
      assign w_v   = r_inV;
      assign w_low = w_seg[SEG-1:0];
    end else begin : g_src
      assign w_a   = g_stage[k-1].g_reg.r_a;
      assign w_b   = g_stage[k-1].g_reg.r_b;
      assign w_c   = g_stage[k-1].g_reg.r_c;
      assign w_v   = g_stage[k-1].g_reg.r_v;
      assign w_low = {w_seg[SEG-1:0], g_stage[k-1].g_reg.r_low};
    end

    assign w_seg = claSeg(w_a[k*SEG +: SEG], w_b[k*SEG +: SEG], w_c);

    if (k < STAGES - 1) begin : g_reg
      // Upper operand bits are skewed forward, finished low bits de-skewed alongside.
      logic [WIDTH-1:(k+1)*SEG] r_a;
      logic [WIDTH-1:(k+1)*SEG] r_b;
      logic [(k+1)*SEG-1:0]     r_low;
      logic                     r_c;
      logic                     r_v;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v <= 1'b0;
        end else if (w_advance) begin
          r_v <= w_v;
        end
      end

      always_ff @(posedge clk) begin
        if (w_advance) begin
          r_a   <= w_a[WIDTH-1:(k+1)*SEG];
          r_b   <= w_b[WIDTH-1:(k+1)*SEG];
          r_c   <= w_seg[SEG];
          r_low <= w_low;
        end
      end
    end else begin : g_out
      // Result registers only update on a valid op so bubbles leave the last result showing.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_outValid <= 1'b0;
          r_sum      <= '0;
          r_cout     <= 1'b0;
          r_ovf      <= 1'b0;
          r_zero     <= 1'b0;
        end else if (w_advance) begin
          r_outValid <= w_v;
          if (w_v) begin
            r_sum  <= w_low;
            r_cout <= w_seg[SEG];
            r_ovf  <= (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_low[WIDTH-1] != w_a[WIDTH-1]);
            r_zero <= ~|w_low;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed-vector and scoreboard bench for pipelined_cla_adder: the default
// 64/4/4 build plus a STAGES=1 and a WIDTH=32/STAGES=2 build fed in parallel.
module tb_pipelined_cla_adder;

  localparam int LAT = 4;
  localparam int NRAND = 3000;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    string       name;
    logic        op;
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    logic [63:0] expSum;
    logic        expCout;
    logic        expOvf;
    logic        expZero;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic        op;
  logic        cin;
  logic        outReady;
  logic [63:0] in1;
  logic [63:0] in2;

  logic        inReady0, outValid0, cout0, ovf0, zero0;
  logic [63:0] sum0;
  logic        inReady1, outValid1, cout1, ovf1, zero1;
  logic [63:0] sum1;
  logic        inReady2, outValid2, cout2, ovf2, zero2;
  logic [31:0] sum2;

  int   checks = 0;
  int   errors = 0;
  bit   monMain = 1'b0;
  res_t q0[$];
  res_t q1[$];
  res_t q2[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(64), .STAGES(4), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady0), .op(op),
    .in1(in1), .in2(in2), .cin(cin), .out_valid(outValid0), .out_ready(outReady),
    .sum(sum0), .cout(cout0), .overflow(ovf0), .zero(zero0)
  );

  pipelined_cla_adder #(.WIDTH(64), .STAGES(1), .GROUP(4)) dutOne (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady1), .op(op),
    .in1(in1), .in2(in2), .cin(cin), .out_valid(outValid1), .out_ready(1'b1),
    .sum(sum1), .cout(cout1), .overflow(ovf1), .zero(zero1)
  );

  pipelined_cla_adder #(.WIDTH(32), .STAGES(2), .GROUP(4)) dutNarrow (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady2), .op(op),
    .in1(in1[31:0]), .in2(in2[31:0]), .cin(cin), .out_valid(outValid2), .out_ready(1'b1),
    .sum(sum2), .cout(cout2), .overflow(ovf2), .zero(zero2)
  );

  // Reference: wide integer add on masked operands, flags from the definitions.
  function automatic res_t model(input int w, input logic o, input logic [63:0] a,
                                 input logic [63:0] b, input logic c);
    logic [64:0] full;
    logic [63:0] mask;
    logic [63:0] aa;
    logic [63:0] bp;
    res_t        r;
    mask   = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    aa     = a & mask;
    bp     = (o ? ~b : b) & mask;
    full   = {1'b0, aa} + {1'b0, bp} + {64'd0, c};
    r.sum  = full[63:0] & mask;
    r.cout = full[w];
    r.ovf  = (aa[w-1] == bp[w-1]) && (r.sum[w-1] != aa[w-1]);
    r.zero = (r.sum == 64'd0);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic checkRes(input string name, input logic [63:0] s, input logic c,
                          input logic v, input logic z, input res_t e);
    checkOutput({name, "_sum"}, s, e.sum);
    checkOutput({name, "_cout"}, {63'd0, c}, {63'd0, e.cout});
    checkOutput({name, "_ovf"}, {63'd0, v}, {63'd0, e.ovf});
    checkOutput({name, "_zero"}, {63'd0, z}, {63'd0, e.zero});
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got=unexpected result expected=none", name);
  endtask

  // Scoreboards: pop on a consumed result, push on an accepted operand, flush on reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      if (monMain && outValid0 && outReady) begin
        if (q0.size() == 0) unexpected("main");
        else checkRes("main", sum0, cout0, ovf0, zero0, q0.pop_front());
      end
      if (outValid1) begin
        if (q1.size() == 0) unexpected("one");
        else checkRes("one", sum1, cout1, ovf1, zero1, q1.pop_front());
      end
      if (outValid2) begin
        if (q2.size() == 0) unexpected("narrow");
        else checkRes("narrow", {32'd0, sum2}, cout2, ovf2, zero2, q2.pop_front());
      end
      if (monMain && inValid && inReady0) q0.push_back(model(64, op, in1, in2, cin));
      if (inValid && inReady1) q1.push_back(model(64, op, in1, in2, cin));
      if (inValid && inReady2) q2.push_back(model(32, op, in1, in2, cin));
    end
  end

  task automatic applyStimulus(input vec_t v);
    int lat;
    op = v.op; in1 = v.a; in2 = v.b; cin = v.c; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    lat = 0;
    while (!outValid0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({v.name, "_lat"}, 64'(lat), 64'(LAT));
    checkRes(v.name, sum0, cout0, ovf0, zero0, '{v.expSum, v.expCout, v.expOvf, v.expZero});
    @(posedge clk); #1;
    checkOutput({v.name, "_bubble"}, {63'd0, outValid0}, 64'd0);
    checkOutput({v.name, "_hold"}, sum0, v.expSum);
  endtask

  // Reset asserted mid-cycle while a valid result is being held by backpressure.
  task automatic resetWhileValid();
    int w;
    outReady = 1'b0;
    op = 1'b0; in1 = 64'h7FFF_FFFF_FFFF_FFFF; in2 = 64'd1; cin = 1'b0; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    w = 0;
    while (!outValid0 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    checkOutput("rstPre_valid", {63'd0, outValid0}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", {63'd0, outValid0}, 64'd0);
    checkOutput("rst_sum", sum0, 64'd0);
    checkOutput("rst_flags", {61'd0, cout0, ovf0, zero0}, 64'd0);
    #10 rst_n = 1'b1;
    outReady = 1'b1;
    #1;
    checkOutput("rstRel_inReady", {63'd0, inReady0}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic runBackpressure();
    fork
      begin
        bit acc;
        int guard;
        for (int i = 1; i <= 6; i++) begin
          in1 = 64'(i); in2 = 64'(i); op = 1'b0; cin = 1'b0; inValid = 1'b1;
          guard = 0;
          do begin
            @(negedge clk); #1;
            acc = inReady0;
            @(posedge clk); #1;
            guard++;
          end while (!acc && guard < 50);
        end
        inValid = 1'b0;
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!outValid0 && w < 50) begin
          @(negedge clk);
          w++;
        end
        checkOutput("bp_first_valid", {63'd0, outValid0}, 64'd1);
        checkOutput("bp_first_sum", sum0, 64'd2);
        outReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(posedge clk);
          @(negedge clk);
          checkOutput("bp_stall_inReady", {63'd0, inReady0}, 64'd0);
          checkOutput("bp_stall_valid", {63'd0, outValid0}, 64'd1);
          checkOutput("bp_stall_sum", sum0, 64'd2);
        end
        outReady = 1'b1;
        for (int j = 2; j <= 6; j++) begin
          @(negedge clk);
          checkOutput("bp_seq_valid", {63'd0, outValid0}, 64'd1);
          checkOutput("bp_seq_sum", sum0, 64'(2 * j));
        end
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic resetInFlight();
    int seen;
    for (int i = 0; i < 3; i++) begin
      op = 1'b0; in1 = 64'(100 + i); in2 = 64'd1; cin = 1'b0; inValid = 1'b1;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (outValid0) seen++;
    end
    checkOutput("flush_none_emerge", 64'(seen), 64'd0);
  endtask

  task automatic randomOp();
    in1 = {$urandom, $urandom};
    in2 = {$urandom, $urandom};
    op  = 1'($urandom_range(1));
    cin = 1'($urandom_range(1));
  endtask

  task automatic runRandom(input int n);
    int issued;
    int guard;
    bit acc;
    issued = 0;
    guard = 0;
    monMain = 1'b1;
    randomOp();
    inValid = 1'b1;
    outReady = ($urandom_range(3) != 0);
    while (issued < n && guard < n * 8) begin
      @(negedge clk); #1;
      acc = inReady0;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        issued++;
        randomOp();
      end
      outReady = ($urandom_range(3) != 0);
    end
    checkOutput("rand_issued", 64'(issued), 64'(n));
    inValid = 1'b0;
    outReady = 1'b1;
    guard = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("drain_main", 64'(q0.size()), 64'd0);
    checkOutput("drain_one", 64'(q1.size()), 64'd0);
    checkOutput("drain_narrow", 64'(q2.size()), 64'd0);
  endtask

  initial begin
    vecs[0] = '{"add_cin", 1'b0, 64'd3232797, 64'd3243579, 1'b1, 64'd6476377, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"ripple", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{"sub_neg", 1'b1, 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"zero_add", 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"sub_equal", 1'b1, 64'd9, 64'd9, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{"sub_ovf", 1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{"neg_ovf", 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                64'd0, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{"pos_ovf", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b1;
    op = 1'b0; cin = 1'b0; in1 = 64'd0; in2 = 64'd0;
    #2;
    checkOutput("reset_valid", {63'd0, outValid0}, 64'd0);
    checkOutput("reset_sum", sum0, 64'd0);
    checkOutput("reset_flags", {61'd0, cout0, ovf0, zero0}, 64'd0);
    #10 rst_n = 1'b1;
    #1;
    checkOutput("reset_inReady", {63'd0, inReady0}, 64'd1);
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    foreach (vecs[i]) applyStimulus(vecs[i]);

    $display("[TB] asynchronous reset with held result");
    resetWhileValid();

    $display("[TB] backpressure sequence");
    runBackpressure();

    $display("[TB] reset with operations in flight");
    resetInFlight();

    $display("[TB] random traffic with random backpressure");
    runRandom(NRAND);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
